// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: registered PC redirect, pipeline flushes, EX/MEM fields, perf counters.
// Optional BRANCH_PREDICT_EN adds ex_pred_taken and redirects only on misprediction (or JALR).
module branch_resolve_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  ex_valid,
   input  logic                  ex_branch,
   input  logic                  ex_jal,
   input  logic                  ex_jalr,
   input  logic [2:0]            ex_funct3,
   input  logic [DATA_WIDTH-1:0] ex_pc,
   input  logic [DATA_WIDTH-1:0] ex_imm,
   input  logic [4:0]            ex_rd,
   input  logic                  ex_regwrite,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  zero,
   input  logic                  less,
   input  logic                  lessu,
`ifdef BRANCH_PREDICT_EN
   input  logic                  ex_pred_taken,
`endif
   output logic                  redirect,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  mem_valid,
   output logic [4:0]            mem_rd,
   output logic                  mem_regwrite,
   output logic [DATA_WIDTH-1:0] mem_result,
   output logic [CNT_WIDTH-1:0]  perf_branches,
   output logic [CNT_WIDTH-1:0]  perf_redirects
);

   typedef enum logic {RUN, REDIRECT} state_t;

   state_t                state_q, state_d;
   logic                  cond, is_br, taken, accepted, need_redirect, is_cf;
   logic [DATA_WIDTH-1:0] pc4, jump_tgt, tgt;

   always_comb begin
      state_d  = state_q;
      cond     = 1'b0;
      case (ex_funct3)
         3'b000:  cond = zero;
         3'b001:  cond = !zero;
         3'b100:  cond = less;
         3'b101:  cond = !less;
         3'b110:  cond = lessu;
         3'b111:  cond = !lessu;
         default: cond = 1'b0;
      endcase
      // funct3 010/011 are not branch encodings at all
      is_br    = ex_branch && (ex_funct3[2:1] != 2'b01);
      taken    = (is_br && cond) || ex_jal || ex_jalr;
      pc4      = ex_pc + DATA_WIDTH'(4);
      jump_tgt = ex_jalr ? (alu_out & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1}) : (ex_pc + ex_imm);
      accepted = ex_valid && (state_q == RUN) && !stall;
      is_cf    = accepted && (is_br || ex_jal || ex_jalr);
`ifdef BRANCH_PREDICT_EN
      need_redirect = accepted && ((taken != ex_pred_taken) || ex_jalr);
      tgt           = taken ? jump_tgt : pc4;
`else
      need_redirect = accepted && taken;
      tgt           = jump_tgt;
`endif
      if (!stall) begin
         case (state_q)
            RUN:      if (need_redirect) state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= RUN;
         redirect       <= 1'b0;
         redirect_pc    <= '0;
         flush_ifid     <= 1'b0;
         flush_idex     <= 1'b0;
         mem_valid      <= 1'b0;
         mem_rd         <= '0;
         mem_regwrite   <= 1'b0;
         mem_result     <= '0;
         perf_branches  <= '0;
         perf_redirects <= '0;
      end else if (!stall) begin
         state_q      <= state_d;
         redirect     <= need_redirect;
         flush_ifid   <= need_redirect;
         flush_idex   <= need_redirect;
         if (need_redirect) redirect_pc <= tgt;
         // in REDIRECT accepted is low, so the wrong-path instruction is squashed here
         mem_valid    <= accepted;
         mem_regwrite <= accepted && ex_regwrite;
         if (accepted) begin
            mem_rd     <= ex_rd;
            mem_result <= (ex_jal || ex_jalr) ? pc4 : alu_out;
         end
         if (is_cf && (perf_branches != '1))          perf_branches  <= perf_branches + 1'b1;
         if (need_redirect && (perf_redirects != '1)) perf_redirects <= perf_redirects + 1'b1;
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage consumer of the ALU result and comparison flags in the pipelined RV32I core. Resolves conditional branches and jumps from the ALU's `Zero`/`Less`/`LessU` flags and result. Issues a registered PC redirect with IF/ID and ID/EX flushes, and squashes the wrong-path instruction. Registers the EX/MEM result fields and keeps branch/mispredict performance counters.

## Interface
- `DATA_WIDTH`, 32, datapath and PC width
- `CNT_WIDTH`, 32, performance counter width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `stall` in 1: memory-stage hold; freezes all state
- `ex_valid` in 1: EX holds a real instruction
- `ex_branch` in 1: conditional branch
- `ex_jal` in 1: JAL
- `ex_jalr` in 1: JALR
- `ex_funct3` in 3: branch condition
- `ex_pc` in DATA_WIDTH: PC of the EX instruction
- `ex_imm` in DATA_WIDTH: sign-extended immediate
- `ex_rd` in 5: destination register
- `ex_regwrite` in 1: writes rd
- `alu_out` in DATA_WIDTH: ALU result (rs1+imm for JALR)
- `zero`, `less`, `lessu` in 1 each: ALU equal, signed-less, unsigned-less flags
- `ex_pred_taken` in 1: fetch prediction (present only with `BRANCH_PREDICT_EN`)
- `redirect` out 1: load `redirect_pc` into PC
- `redirect_pc` out DATA_WIDTH: fetch target
- `flush_ifid`, `flush_idex` out 1 each: clear those pipeline registers
- `mem_valid` out 1, `mem_rd` out 5, `mem_regwrite` out 1, `mem_result` out DATA_WIDTH: EX/MEM fields
- `perf_branches` out CNT_WIDTH: resolved branches and jumps
- `perf_redirects` out CNT_WIDTH: redirects issued

## Operation
- Branch condition by `ex_funct3`:
  - 000 `zero`, 001 `!zero`
  - 100 `less`, 101 `!less`
  - 110 `lessu`, 111 `!lessu`
  - 010/011 never taken and do not count as branches
- `taken` = (`ex_branch` & cond) | `ex_jal` | `ex_jalr`.
- Target:
  - branch/JAL: `ex_pc + ex_imm`, mod 2^DATA_WIDTH
  - JALR: `alu_out & ~1`
  - not-taken fallthrough: `ex_pc + 4`
- `mem_result`:
  - JAL/JALR: `ex_pc + 4`
  - otherwise: `alu_out`
- `need_redirect`: the instruction is accepted (`ex_valid`, state RUN, `!stall`) and it is taken.
- FSM, two states:
  - RUN: an accepted instruction with `need_redirect` moves to REDIRECT.
  - REDIRECT: `redirect`, `flush_ifid` and `flush_idex` are high. The EX input is wrong-path and is squashed: `mem_valid`=0, `mem_regwrite`=0, no counter update. Returns to RUN on the next non-stalled edge.
- Counters increment by 1 per accepted branch/jump and per redirect issued. They saturate at all-ones with no wrap.

## Timing
- All outputs are registered.
- EX/MEM fields update one cycle after the EX inputs.
- `redirect`, `redirect_pc` and the flushes go high the cycle after the branch is in EX and stay high for exactly one non-stalled cycle.
- Stall: the state, all outputs and the counters hold. If `stall` is high in REDIRECT, `redirect` stays high until the first cycle with `stall` low, then drops.
- `ex_valid`=0: `mem_valid`=0, no redirect.
- Back-to-back branches: the second branch is in REDIRECT and is squashed, so it never redirects.
- Reset, at any state including mid-REDIRECT: the next edge with `rst_n`=0 clears everything.
  - State returns to RUN.
  - All outputs go to 0: `redirect`, the flushes, `redirect_pc`, the `mem_*` fields and the counters.
  - Outputs stay 0 while `rst_n` is held low.

## Configuration
- `BRANCH_PREDICT_EN` defined:
  - The `ex_pred_taken` port exists.
  - `need_redirect` = accepted & (`taken` != `ex_pred_taken` | `ex_jalr`).
  - On a predicted-taken, not-taken branch, `redirect_pc` = `ex_pc + 4`.
  - `perf_redirects` counts mispredictions.
- Undefined:
  - No `ex_pred_taken` port; static not-taken.
  - Every taken branch/JAL/JALR redirects.

## Test plan
- BEQ, `zero`=1, `ex_pc`=0x100, `ex_imm`=0x20 -> next cycle `redirect`=1 with `redirect_pc`=0x120 and both flushes high for one cycle. Following EX instruction squashed (`mem_valid`=0). `perf_branches`=1, `perf_redirects`=1.
- BLTU, `lessu`=0 -> no redirect, `mem_valid`=1, `perf_branches`=1, `perf_redirects`=0.
- JALR `alu_out`=0x2003, `ex_pc`=0x40, `ex_rd`=1 -> `redirect_pc`=0x2002, `mem_result`=0x44, `mem_regwrite`=1.
- Taken BNE, then `stall`=1 for 3 cycles during REDIRECT -> `redirect` held through the stall, deasserted one cycle after `stall` falls; counters unchanged during the stall.
- `rst_n`=0 for one cycle while in REDIRECT -> all outputs 0 after that edge; a following not-taken branch resolves normally.
- `BRANCH_PREDICT_EN`: BGE, `less`=1, `ex_pred_taken`=1, `ex_pc`=0x80 -> `redirect_pc`=0x84. Correctly predicted taken BEQ -> no redirect.
